// File: rtl/v_bytewrite_coalescer_pkg.sv
// Shared types and helpers for the byte-write coalescer and its lane merge.
// Holds the FSM state encoding and lane slicing arithmetic.
package v_bytewrite_coalescer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StRd   = 2'd2
  } state_e;

  function automatic int unsigned data_width(input int unsigned nb_col,
                                             input int unsigned col_width);
    return nb_col * col_width;
  endfunction

  // Low bit index of a given lane inside a packed word.
  function automatic int unsigned lane_lo(input int unsigned lane,
                                          input int unsigned col_width);
    return lane * col_width;
  endfunction

endpackage

// File: rtl/v_bytewrite_coalescer_if.sv
// Request/response bus of the byte-write coalescer: valid/ready requests in,
// single-cycle read data pulses out.
interface v_bytewrite_coalescer_if
  import v_bytewrite_coalescer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned NB_COL     = 2
);

  localparam int unsigned DataW = data_width(NB_COL, COL_WIDTH);

  logic                  s_valid;
  logic                  s_ready;
  logic                  s_write;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [NB_COL-1:0]     s_be;
  logic [DataW-1:0]      s_data;
  logic                  r_valid;
  logic [DataW-1:0]      r_data;

  modport master (
    output s_valid, s_write, s_addr, s_be, s_data,
    input  s_ready, r_valid, r_data
  );

  modport slave (
    input  s_valid, s_write, s_addr, s_be, s_data,
    output s_ready, r_valid, r_data
  );

endinterface

// File: rtl/v_bytewrite_lane_merge.sv
// Combinational lane-wise merge: lanes enabled in s_be take s_data, the rest
// keep pend_data; enables are OR-ed.
module v_bytewrite_lane_merge
  import v_bytewrite_coalescer_pkg::*;
#(
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned NB_COL    = 2
) (
  input  logic [NB_COL*COL_WIDTH-1:0] pend_data_i,
  input  logic [NB_COL-1:0]           pend_be_i,
  input  logic [NB_COL*COL_WIDTH-1:0] s_data_i,
  input  logic [NB_COL-1:0]           s_be_i,
  output logic [NB_COL*COL_WIDTH-1:0] merged_data_o,
  output logic [NB_COL-1:0]           merged_be_o
);

  always_comb begin
    merged_data_o = pend_data_i;
    for (int unsigned i = 0; i < NB_COL; i++) begin
      if (s_be_i[i]) begin
        merged_data_o[lane_lo(i, COL_WIDTH) +: COL_WIDTH] =
            s_data_i[lane_lo(i, COL_WIDTH) +: COL_WIDTH];
      end
    end
  end

  assign merged_be_o = pend_be_i | s_be_i;

endmodule

// File: rtl/v_bytewrite_coalescer.sv
// Write-combining front end for a single-port byte-write BRAM: merges
// same-address writes into one RAM write and orders reads behind the flush.
module v_bytewrite_coalescer
  import v_bytewrite_coalescer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned COL_WIDTH     = 8,
  parameter int unsigned NB_COL        = 2,
  parameter int unsigned FLUSH_TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  v_bytewrite_coalescer_if.slave       bus,
  input  logic                         flush,
  output logic                         idle,
  output logic [NB_COL-1:0]            ram_we,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]  ram_di,
  input  logic [NB_COL*COL_WIDTH-1:0]  ram_do
);

  localparam int unsigned DataW = data_width(NB_COL, COL_WIDTH);
  localparam int unsigned CntW  = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FLUSH_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [NB_COL-1:0]     pend_be_q, pend_be_d;
  logic [DataW-1:0]      pend_data_q, pend_data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [DataW-1:0]  merged_data;
  logic [NB_COL-1:0] merged_be;
  logic              wr_real, rd_req, same_addr, do_flush;
  logic              s_ready, r_valid;

  v_bytewrite_lane_merge #(
    .COL_WIDTH (COL_WIDTH),
    .NB_COL    (NB_COL)
  ) u_lane_merge (
    .pend_data_i   (pend_data_q),
    .pend_be_i     (pend_be_q),
    .s_data_i      (bus.s_data),
    .s_be_i        (bus.s_be),
    .merged_data_o (merged_data),
    .merged_be_o   (merged_be)
  );

  // Zero-enable writes are accepted but behave as if nothing arrived.
  assign wr_real   = bus.s_valid && bus.s_write && (bus.s_be != '0);
  assign rd_req    = bus.s_valid && !bus.s_write;
  assign same_addr = (bus.s_addr == pend_addr_q);

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_be_d   = pend_be_q;
    pend_data_d = pend_data_q;
    cnt_d       = cnt_q;
    s_ready     = 1'b0;
    r_valid     = 1'b0;
    do_flush    = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_ready = 1'b1;
        if (wr_real) begin
          pend_addr_d = bus.s_addr;
          pend_be_d   = bus.s_be;
          pend_data_d = bus.s_data;
          cnt_d       = '0;
          state_d     = StHold;
        end else if (rd_req) begin
          state_d = StRd;
        end
      end
      StHold: begin
        // Reads stall here so the flush lands before their RAM access.
        s_ready = bus.s_write;
        if (wr_real && same_addr) begin
          pend_be_d   = merged_be;
          pend_data_d = merged_data;
          cnt_d       = '0;
        end else if (wr_real) begin
          do_flush    = 1'b1;
          pend_addr_d = bus.s_addr;
          pend_be_d   = bus.s_be;
          pend_data_d = bus.s_data;
          cnt_d       = '0;
        end else if (rd_req || flush || (cnt_q == CntLast)) begin
          do_flush = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRd: begin
        r_valid = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      s_ready  = 1'b0;
      r_valid  = 1'b0;
      do_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_addr_q <= '0;
      pend_be_q   <= '0;
      pend_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_be_q   <= pend_be_d;
      pend_data_q <= pend_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_we      = do_flush ? pend_be_q : '0;
  assign ram_addr    = do_flush ? pend_addr_q : bus.s_addr;
  assign ram_di      = pend_data_q;
  assign idle        = (state_q == StIdle);
  assign bus.s_ready = s_ready;
  assign bus.r_valid = r_valid;
  assign bus.r_data  = ram_do;

endmodule

// File: tb/tb_v_bytewrite_coalescer.sv
// Bench for v_bytewrite_coalescer: directed vector table, reset corner case,
// and randomized traffic against a behavioural model plus a byte-write RAM.
module tb_v_bytewrite_coalescer;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned FT = 4;
  localparam int unsigned DW = NC * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          idle;
  logic [NC-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  v_bytewrite_coalescer_if #(.ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC)) bus ();

  v_bytewrite_coalescer #(
    .ADDR_WIDTH    (AW),
    .COL_WIDTH     (CW),
    .NB_COL        (NC),
    .FLUSH_TIMEOUT (FT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .idle     (idle),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 clk = ~clk;

  // Byte-write RAM with registered read; never-written words read a fixed pattern.
  logic [DW-1:0] mem [1024];
  bit            wr_mask [1024];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 16'(a) * 16'h9E37 + 16'h1234;
  endfunction

  function automatic logic [DW-1:0] wmerge(input logic [DW-1:0] old, input logic [DW-1:0] di,
                                           input logic [NC-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NC; i++) if (we[i]) r[CW*i +: CW] = di[CW*i +: CW];
    return r;
  endfunction

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return wr_mask[a] ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    ram_do <= ram_rd(ram_addr);
    if (ram_we != '0) begin
      mem[ram_addr]     <= wmerge(ram_rd(ram_addr), ram_di, ram_we);
      wr_mask[ram_addr] <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: one pending write slot, an idle age, a read in flight,
  // and a shadow of what the RAM should hold.
  logic [DW-1:0] shadow [1024];
  bit            m_pend, n_pend, m_rd, n_rd;
  logic [AW-1:0] m_paddr, n_paddr;
  logic [NC-1:0] m_pbe, n_pbe;
  logic [DW-1:0] m_pdata, n_pdata, m_rdata, n_rdata;
  int            m_age, n_age;
  logic [NC-1:0] sh_we;
  logic [AW-1:0] sh_addr;
  logic [DW-1:0] sh_di;
  logic          e_rdy, e_rv, e_achk, e_idle;
  logic [NC-1:0] e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_di, e_rd;

  task automatic model_eval(input logic v, w, input logic [AW-1:0] a, input logic [NC-1:0] be,
                            input logic [DW-1:0] d, input logic fl);
    bit real_wr;
    real_wr = v && w && (be != '0);
    n_pend = m_pend; n_rd = m_rd; n_paddr = m_paddr; n_pbe = m_pbe;
    n_pdata = m_pdata; n_rdata = m_rdata; n_age = m_age;
    sh_we = '0; sh_addr = '0; sh_di = '0;
    e_rv = 1'b0; e_rd = '0; e_we = '0; e_achk = 1'b0; e_addr = '0; e_di = '0;
    if (rst) begin
      e_rdy = 1'b0; e_idle = 1'b1;
      n_pend = 0; n_rd = 0; n_age = 0;
    end else begin
      e_idle = !m_pend && !m_rd;
      if (m_rd) begin
        e_rdy = 1'b0; e_rv = 1'b1; e_rd = m_rdata; n_rd = 0;
      end else if (!m_pend) begin
        e_rdy = 1'b1;
        if (real_wr) begin
          n_pend = 1; n_paddr = a; n_pbe = be; n_pdata = d; n_age = 0;
        end else if (v && !w) begin
          n_rd = 1; e_achk = 1'b1; e_addr = a; n_rdata = shadow[a];
        end
      end else begin
        e_rdy = w;
        if (real_wr && a == m_paddr) begin
          n_pbe = m_pbe | be; n_pdata = wmerge(m_pdata, d, be); n_age = 0;
        end else if (real_wr || (v && !w) || fl || m_age == FT - 1) begin
          e_we = m_pbe; e_achk = 1'b1; e_addr = m_paddr; e_di = m_pdata;
          sh_we = m_pbe; sh_addr = m_paddr; sh_di = m_pdata;
          n_pend = real_wr; n_age = 0;
          if (real_wr) begin n_paddr = a; n_pbe = be; n_pdata = d; end
        end else begin
          n_age = m_age + 1;
        end
      end
    end
  endtask

  task automatic model_commit();
    if (sh_we != '0) shadow[sh_addr] = wmerge(shadow[sh_addr], sh_di, sh_we);
    m_pend = n_pend; m_rd = n_rd; m_paddr = n_paddr; m_pbe = n_pbe;
    m_pdata = n_pdata; m_rdata = n_rdata; m_age = n_age;
  endtask

  logic          smp_rdy, smp_rv, smp_idle;
  logic [NC-1:0] smp_we;
  logic [AW-1:0] smp_addr;
  logic [DW-1:0] smp_di, smp_rd;

  task automatic cycle(input logic v, w, input logic [AW-1:0] a, input logic [NC-1:0] be,
                       input logic [DW-1:0] d, input logic fl);
    logic [DW-1:0] dm;
    bus.s_valid = v; bus.s_write = w; bus.s_addr = a; bus.s_be = be; bus.s_data = d;
    flush = fl;
    model_eval(v, w, a, be, d, fl);
    @(negedge clk);
    smp_rdy = bus.s_ready; smp_rv = bus.r_valid; smp_rd = bus.r_data; smp_idle = idle;
    smp_we = ram_we; smp_addr = ram_addr; smp_di = ram_di;
    dm = {{CW{e_we[1]}}, {CW{e_we[0]}}};
    chk("m_rdy", 32'(smp_rdy), 32'(e_rdy));
    chk("m_rvalid", 32'(smp_rv), 32'(e_rv));
    if (e_rv) chk("m_rdata", 32'(smp_rd), 32'(e_rd));
    chk("m_we", 32'(smp_we), 32'(e_we));
    if (e_achk) chk("m_addr", 32'(smp_addr), 32'(e_addr));
    if (e_we != '0) chk("m_di", 32'(smp_di & dm), 32'(e_di & dm));
    chk("m_idle", 32'(smp_idle), 32'(e_idle));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  typedef struct {
    logic          v, w;
    logic [AW-1:0] a;
    logic [NC-1:0] be;
    logic [DW-1:0] d;
    logic          fl;
    logic          rdy;
    logic [NC-1:0] we;
    logic          achk;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    logic          rv;
    logic [DW-1:0] rd;
    logic          idl;
  } row_t;

  row_t rows[$];

  task automatic add(input logic v, w, input int a, input logic [NC-1:0] be, input int d,
                     input logic fl, input logic rdy, input logic [NC-1:0] we, input logic achk,
                     input int addr, input int di, input logic rv, input int rd, input logic idl);
    row_t r;
    r.v = v; r.w = w; r.a = AW'(a); r.be = be; r.d = DW'(d); r.fl = fl;
    r.rdy = rdy; r.we = we; r.achk = achk; r.addr = AW'(addr); r.di = DW'(di);
    r.rv = rv; r.rd = DW'(rd); r.idl = idl;
    rows.push_back(r);
  endtask

  task automatic quiet(input int n, input logic rdy, input logic idl);
    for (int i = 0; i < n; i++) add(0, 0, 0, 2'b00, 0, 0, rdy, 2'b00, 0, 0, 0, 0, 0, idl);
  endtask

  initial begin
    logic          hv, hw, hfl, last_rdy;
    logic [AW-1:0] ha;
    logic [NC-1:0] hbe;
    logic [DW-1:0] hd;
    int            bad;

    for (int i = 0; i < 1024; i++) shadow[i] = init_val(AW'(i));
    m_pend = 0; m_rd = 0; m_age = 0; m_paddr = '0; m_pbe = '0; m_pdata = '0; m_rdata = '0;
    rst = 1'b1;

    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(1, 1, 1, 2'b11, 16'h1111, 1);
    chk("rst_rdy", 32'(smp_rdy), 0);
    chk("rst_we", 32'(smp_we), 0);
    chk("rst_rvalid", 32'(smp_rv), 0);
    chk("rst_idle", 32'(smp_idle), 1);
    rst = 1'b0;

    // Merge two lanes, timeout flush, then read back.
    add(1, 1, 5, 2'b01, 'h00AA, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    add(1, 1, 5, 2'b10, 'hBB00, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    quiet(3, 0, 0);
    add(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 1, 5, 'hBBAA, 0, 0, 0);
    quiet(1, 1, 1);
    add(1, 0, 5, 2'b00, 0, 0, 1, 2'b00, 1, 5, 0, 0, 0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 'hBBAA, 0);
    quiet(1, 1, 1);
    // Address change flushes in the same cycle; second write times out.
    add(1, 1, 5, 2'b01, 'h0011, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    add(1, 1, 6, 2'b11, 'h2233, 0, 1, 2'b01, 1, 5, 'h0011, 0, 0, 0);
    quiet(3, 0, 0);
    add(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 1, 6, 'h2233, 0, 0, 0);
    quiet(1, 1, 1);
    // Read after write to the same address.
    add(1, 1, 7, 2'b11, 'h1234, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    add(1, 0, 7, 2'b00, 0, 0, 0, 2'b11, 1, 7, 'h1234, 0, 0, 0);
    add(1, 0, 7, 2'b00, 0, 0, 1, 2'b00, 1, 7, 0, 0, 0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 'h1234, 0);
    quiet(1, 1, 1);
    // Zero-enable write plus flush.
    add(1, 1, 2, 2'b11, 'h5555, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    add(1, 1, 2, 2'b00, 'h0F0F, 1, 1, 2'b11, 1, 2, 'h5555, 0, 0, 0);
    quiet(1, 1, 1);
    // Zero-enable write and flush while idle do nothing.
    add(1, 1, 9, 2'b00, 'hABCD, 1, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    // Zero-enable write in HOLD keeps the idle count running.
    add(1, 1, 4, 2'b11, 'hCAFE, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    quiet(2, 0, 0);
    add(1, 1, 4, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 1, 4, 'hCAFE, 0, 0, 0);
    quiet(1, 1, 1);
    // Same-address merge wins over flush.
    add(1, 1, 8, 2'b01, 'h0011, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
    add(1, 1, 8, 2'b10, 'h2200, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2'b00, 0, 1, 0, 2'b11, 1, 8, 'h2211, 0, 0, 0);
    add(1, 0, 8, 2'b00, 0, 0, 1, 2'b00, 1, 8, 0, 0, 0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 'h2211, 0);
    quiet(1, 1, 1);

    foreach (rows[i]) begin
      cycle(rows[i].v, rows[i].w, rows[i].a, rows[i].be, rows[i].d, rows[i].fl);
      chk($sformatf("tbl%0d_rdy", i), 32'(smp_rdy), 32'(rows[i].rdy));
      chk($sformatf("tbl%0d_we", i), 32'(smp_we), 32'(rows[i].we));
      if (rows[i].achk) chk($sformatf("tbl%0d_addr", i), 32'(smp_addr), 32'(rows[i].addr));
      if (rows[i].we != '0) chk($sformatf("tbl%0d_di", i), 32'(smp_di), 32'(rows[i].di));
      chk($sformatf("tbl%0d_rvalid", i), 32'(smp_rv), 32'(rows[i].rv));
      if (rows[i].rv) chk($sformatf("tbl%0d_rdata", i), 32'(smp_rd), 32'(rows[i].rd));
      chk($sformatf("tbl%0d_idle", i), 32'(smp_idle), 32'(rows[i].idl));
    end

    // Reset while a write is pending: it must never reach the RAM.
    cycle(1, 1, 3, 2'b11, 16'hFFFF, 0);
    bus.s_valid = 1'b0; bus.s_write = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("rsthold_we", 32'(ram_we), 0);
    chk("rsthold_idle", 32'(idle), 1);
    chk("rsthold_rdy", 32'(bus.s_ready), 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < FT + 2; i++) begin
      cycle(0, 0, 0, 2'b00, 0, 0);
      chk("rsthold_nowe", 32'(smp_we), 0);
    end
    cycle(1, 0, 3, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    chk("rsthold_rvalid", 32'(smp_rv), 1);
    chk("rsthold_rdata", 32'(smp_rd), 32'(init_val(AW'(3))));
    cycle(0, 0, 0, 2'b00, 0, 0);

    // Randomized traffic on a few hot addresses; stalled requests are held.
    hv = 1'b0; hw = 1'b0; ha = '0; hbe = '0; hd = '0; last_rdy = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!(hv && !last_rdy)) begin
        hv  = $urandom_range(0, 99) < 55;
        hw  = $urandom_range(0, 99) < 65;
        ha  = AW'($urandom_range(0, 3));
        hbe = NC'($urandom_range(0, 3));
        hd  = DW'($urandom);
      end
      hfl = $urandom_range(0, 99) < 8;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      cycle(hv, hw, ha, hbe, hd, hfl);
      last_rdy = e_rdy;
      rst = 1'b0;
    end

    cycle(0, 0, 0, 2'b00, 0, 1);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram_rd(AW'(i)) !== shadow[i]) bad++;
    chk("ram_contents_bad_words", 32'(bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/v_bytewrite_coalescer.md
# v_bytewrite_coalescer

Write-combining front end for the single-port byte-write-enable BRAM: accepts byte-lane write requests and word read requests over a valid/ready interface, merges consecutive writes to the same address into one RAM write with OR-ed column enables, and issues reads with hazard-free ordering. Sits directly upstream of the byte-write RAM and drives its `we`/`addr`/`di` ports. It consumes the RAM's registered `do` output.

## Interface
- `ADDR_WIDTH`, 10: RAM address width.
- `COL_WIDTH`, 8: bits per column (byte lane).
- `NB_COL`, 2: number of columns.
- `FLUSH_TIMEOUT`, 4: idle cycles before a pending write is flushed; must be ≥1.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `s_valid`  in  1: request valid.
- `s_ready`  out  1: request accepted when `s_valid && s_ready`.
- `s_write`  in  1: 1 = write, 0 = read.
- `s_addr`  in  ADDR_WIDTH: request address.
- `s_be`  in  NB_COL: per-column write enable; ignored for reads.
- `s_data`  in  NB_COL*COL_WIDTH: write data.
- `r_valid`  out  1: read data valid, single-cycle pulse, no backpressure.
- `r_data`  out  NB_COL*COL_WIDTH: read data.
- `flush`  in  1: force flush of the pending write.
- `idle`  out  1: no pending write and no read outstanding.
- `ram_we`  out  NB_COL: to RAM `we`.
- `ram_addr`  out  ADDR_WIDTH: to RAM `addr`.
- `ram_di`  out  NB_COL*COL_WIDTH: to RAM `di`.
- `ram_do`  in  NB_COL*COL_WIDTH: from RAM `do`, valid the cycle after its address is presented.

## Operation
- Registered state: FSM state, pending buffer (`pend_addr`, `pend_be`, `pend_data`), and idle counter `cnt` of width clog2(FLUSH_TIMEOUT).
- `ram_*`, `s_ready`, `r_*` and `idle` are combinational from registered state and current inputs. `ram_we` is zero except in flush cycles.
- States:
  - IDLE:
    - `s_ready` = 1.
    - Write with `s_be` ≠ 0: capture into the buffer, `cnt` = 0, go to HOLD. No RAM write occurs.
    - Read: `ram_addr` = `s_addr`, `ram_we` = 0, go to RD.
    - `flush`: no effect.
  - HOLD:
    - `s_ready` = `s_write`. Reads stall.
    - Write to the same address: lane-wise merge, where each lane with `s_be[i]` takes `s_data` and the others keep `pend_data`; `pend_be` |= `s_be`; `cnt` = 0. No flush.
    - Write to a different address: flush the pending write this cycle and capture the new write; stay in HOLD with `cnt` = 0.
    - Read pending (`s_valid && !s_write`), `flush`, or `cnt` == FLUSH_TIMEOUT-1 with no accepted write: flush, go to IDLE.
    - Otherwise: `cnt`++.
  - RD:
    - `s_ready` = 0; `r_valid` = 1; `r_data` = `ram_do`; go to IDLE.
- Flush cycle: `ram_we` = `pend_be`, `ram_addr` = `pend_addr`, `ram_di` = `pend_data`.
- Priority in HOLD: a same-address write merge beats timeout and `flush`. A read or `flush` on a non-write cycle beats the idle count.
- Write with `s_be` == 0: accepted and discarded. It does not reset `cnt` and does not change state.
- `idle` = (state == IDLE).
- Reset, asynchronous: state IDLE, `pend_*` = 0, `cnt` = 0. While in reset, `s_ready` = 0, `r_valid` = 0, `ram_we` = 0, `idle` = 1. A pending write is discarded on reset and never reaches the RAM.

## Timing
- Read accepted in cycle N → `r_valid` in cycle N+1.
- A read arriving in HOLD is stalled exactly one cycle (the flush cycle), then accepted. Read-after-write to the same address therefore returns the merged data.
- Last accepted write in cycle N with no further activity → flush in cycle N+FLUSH_TIMEOUT, `idle` = 1 from N+FLUSH_TIMEOUT+1.
- Back-to-back writes sustain one write per cycle, with no bubbles.

## Structure
- Shared package holds the FSM state encoding (IDLE, HOLD, RD) and a lane-slice width constant function.
- Sub-module `v_bytewrite_lane_merge`: combinational lane-wise merge of (`pend_data`, `pend_be`) with (`s_data`, `s_be`). It is reused by any future read-modify-write stage.

## Test plan
All scenarios use default parameters.
- Merge: write addr 5, be=01, data 0x00AA in cycle 0; write addr 5, be=10, data 0xBB00 in cycle 1; then idle. Expect a single RAM write in cycle 5: `ram_we`=11, addr 5, `ram_di`=0xBBAA.
- Address change: write addr 5, be=01, 0x0011, then addr 6, be=11, 0x2233 back-to-back. Expect `ram_we`=01, addr 5, `ram_di`=0x0011 in the second cycle with `s_ready`=1. Addr 6 then flushes on timeout.
- RAW: write addr 7, be=11, 0x1234, then read addr 7 immediately. Expect `s_ready`=0 for one cycle with flush `ram_we`=11, then read accepted, then `r_valid`=1 with `r_data`=0x1234.
- Flush/zero-be: write addr 2, be=11, 0x5555; next cycle a be=00 write plus `flush`=1. Expect the flush in that cycle, the be=00 write has no effect, and `idle`=1 next cycle.
- Reset mid-HOLD: write addr 3, 0xFFFF; assert `rst` in the next cycle. Expect `ram_we` to stay 0, and a subsequent read of addr 3 returns the prior RAM content.
